// File: rtl/ws2812_frame_scheduler.sv
// WS2812 frame sequencer: fetches NUM_LEDS GRB words, paces bit periods, then holds the latch gap.
// Optional abort input/output pair enabled by defining WS2812_SCHED_ABORT_EN.
module ws2812_frame_scheduler #(
   parameter int NUM_LEDS   = 10,
   parameter int BIT_CYCLES = 61,
   parameter int RESET_BITS = 240,
   parameter int IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_continuous,
`ifdef WS2812_SCHED_ABORT_EN
   input  logic             i_abort,
   output logic             o_aborted,
`endif
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_pix_rd,
   output logic [IDX_W-1:0] o_pix_addr,
   input  logic [23:0]      i_pix_data,
   output logic [23:0]      o_enc_pixel,
   output logic             o_enc_load,
   output logic             o_bit_tick,
   output logic [4:0]       o_bit_index,
   output logic             o_sending_data,
   output logic [IDX_W-1:0] o_led_index
);

   localparam int TW = $clog2(BIT_CYCLES);
   localparam int LW = $clog2(RESET_BITS + 1);
   localparam logic [TW-1:0]    TickMax  = TW'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LastLed  = IDX_W'(NUM_LEDS - 1);
   localparam logic [LW-1:0]    LatchMax = LW'(RESET_BITS);
   localparam logic [4:0]       LastBit  = 5'd23;

   typedef enum logic [2:0] {StIdle, StFetch, StWait, StSend, StLatch} state_e;

   state_e           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_led_index, w_led_nxt;
   logic [TW-1:0]    r_tick_cnt, w_tick_nxt;
   logic [4:0]       r_bit_index, w_bit_nxt;
   logic [LW-1:0]    r_latch_cnt, w_latch_nxt;
   logic [23:0]      r_enc_pixel, w_pixel_nxt;
   logic             r_start_pending, w_pend_nxt;

   logic w_last_tick;
   logic w_latch_end;
   logic w_in_data;
   logic w_abort_now;
   logic w_abort_exit;

   assign w_last_tick = (r_tick_cnt == TickMax);
   // Latch counter parks at RESET_BITS for one cycle: that cycle carries frame_done and the exit.
   assign w_latch_end = (r_state == StLatch) && (r_latch_cnt == LatchMax);
   assign w_in_data   = (r_state == StFetch) || (r_state == StWait) || (r_state == StSend);

`ifdef WS2812_SCHED_ABORT_EN
   logic r_abort_req;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_abort_req <= 1'b0;
      end else if (w_latch_end) begin
         r_abort_req <= 1'b0;
      end else if (i_abort && w_in_data) begin
         r_abort_req <= 1'b1;
      end
   end

   // An abort landing on the final bit tick still cuts the frame at this pixel.
   assign w_abort_now  = r_abort_req | (i_abort & w_in_data);
   assign w_abort_exit = r_abort_req;
   assign o_aborted    = w_latch_end & r_abort_req;
`else
   assign w_abort_now  = 1'b0;
   assign w_abort_exit = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= StIdle;
         r_led_index     <= '0;
         r_tick_cnt      <= '0;
         r_bit_index     <= '0;
         r_latch_cnt     <= '0;
         r_enc_pixel     <= '0;
         r_start_pending <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_led_index     <= w_led_nxt;
         r_tick_cnt      <= w_tick_nxt;
         r_bit_index     <= w_bit_nxt;
         r_latch_cnt     <= w_latch_nxt;
         r_enc_pixel     <= w_pixel_nxt;
         r_start_pending <= w_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_led_nxt   = r_led_index;
      w_tick_nxt  = r_tick_cnt;
      w_bit_nxt   = r_bit_index;
      w_latch_nxt = r_latch_cnt;
      w_pixel_nxt = r_enc_pixel;
      w_pend_nxt  = r_start_pending;

      if (i_start && (r_state != StIdle) && !w_latch_end) begin
         w_pend_nxt = 1'b1;
      end

      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_nxt = StFetch;
               w_led_nxt   = '0;
            end
         end
         StFetch: begin
            w_state_nxt = StWait;
         end
         StWait: begin
            w_pixel_nxt = i_pix_data;
            w_bit_nxt   = '0;
            w_tick_nxt  = '0;
            w_state_nxt = StSend;
         end
         StSend: begin
            w_tick_nxt = w_last_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_last_tick) begin
               if (r_bit_index == LastBit) begin
                  w_bit_nxt = '0;
                  if ((r_led_index == LastLed) || w_abort_now) begin
                     w_state_nxt = StLatch;
                     w_tick_nxt  = '0;
                     w_latch_nxt = '0;
                  end else begin
                     w_led_nxt   = r_led_index + 1'b1;
                     w_state_nxt = StFetch;
                  end
               end else begin
                  w_bit_nxt = r_bit_index + 1'b1;
               end
            end
         end
         StLatch: begin
            if (w_latch_end) begin
               w_tick_nxt  = '0;
               w_latch_nxt = '0;
               w_pend_nxt  = 1'b0;
               w_led_nxt   = '0;
               if (!w_abort_exit && (i_continuous || r_start_pending || i_start)) begin
                  w_state_nxt = StFetch;
               end else begin
                  w_state_nxt = StIdle;
               end
            end else begin
               w_tick_nxt = w_last_tick ? '0 : r_tick_cnt + 1'b1;
               if (w_last_tick) begin
                  w_latch_nxt = r_latch_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign o_busy         = (r_state != StIdle);
   assign o_frame_done   = w_latch_end;
   assign o_pix_rd       = (r_state == StFetch);
   assign o_pix_addr     = (r_state == StFetch) ? r_led_index : '0;
   assign o_enc_pixel    = r_enc_pixel;
   assign o_enc_load     = (r_state == StWait);
   assign o_bit_tick     = ((r_state == StSend) || (r_state == StLatch)) && w_last_tick;
   assign o_bit_index    = r_bit_index;
   assign o_sending_data = w_in_data;
   assign o_led_index    = r_led_index;

endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
- Frame-level sequencer for the WS2812 output path. It reads NUM_LEDS 24-bit GRB words from a synchronous pixel RAM and hands each word to the single-LED bit encoder.
- It generates the 1220 ns bit-period tick that the encoder consumes, then holds the line low for the latch/reset gap.
- Replaces the free-running divider chain with an explicit start/busy/done handshake, so upstream logic can rewrite the frame buffer between frames.

Parameters:
- NUM_LEDS, 10, pixels per frame (>=1).
- BIT_CYCLES, 61, clk cycles per bit period (61 at 50 MHz = 1220 ns; >=2).
- RESET_BITS, 240, bit periods of low latch gap after the last pixel (>=1).
- IDX_W, $clog2(NUM_LEDS) (minimum 1), pixel address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to send one frame
- continuous  in  1  when 1, the next frame starts automatically after the latch gap
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at the end of the latch gap
- pix_rd  out  1  pixel RAM read strobe
- pix_addr  out  IDX_W  pixel RAM address (valid while pix_rd)
- pix_data  in  24  RAM read data, valid exactly 1 clk after pix_rd
- enc_pixel  out  24  pixel word presented to the encoder
- enc_load  out  1  one-cycle pulse: enc_pixel is new, bit 0 begins
- bit_tick  out  1  one-cycle pulse per completed bit period
- bit_index  out  5  current bit, 0..23
- sending_data  out  1  high while in FETCH/WAIT/SEND
- led_index  out  IDX_W  pixel currently being sent

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs, led_index, tick_cnt, latch counter and start_pending are 0. Reset mid-frame aborts immediately; there is no partial completion.
- tick_cnt counts 0..BIT_CYCLES-1 and wraps. bit_tick=1 iff tick_cnt==BIT_CYCLES-1 in SEND or LATCH. tick_cnt clears in WAIT and on entering LATCH.
- IDLE:
  - start=1 → FETCH, led_index=0.
  - continuous alone does not start a frame.
- FETCH (1 clk): pix_rd=1, pix_addr=led_index → WAIT.
- WAIT (1 clk): enc_pixel<=pix_data, enc_load=1, bit_index=0 → SEND.
- SEND:
  - Each bit_tick increments bit_index.
  - On the bit_tick with bit_index==23:
    - if led_index==NUM_LEDS-1 → LATCH;
    - else led_index+1 → FETCH.
  - Inter-pixel overhead is exactly 2 clk; each pixel occupies 2+24*BIT_CYCLES clk.
- LATCH:
  - sending_data=0; enc_pixel holds its value.
  - Counts RESET_BITS bit_ticks; on the last one, frame_done=1 for the following cycle.
  - Exit: if continuous or start_pending → FETCH with led_index=0 and start_pending cleared; else → IDLE.
- start while busy sets start_pending (one-deep; extra starts are dropped). start in the same cycle as the IDLE→FETCH transition is consumed, not pended.
- start and a LATCH exit in the same cycle: go to FETCH; start_pending stays 0.
- continuous is sampled only at the LATCH exit.
- Nothing else touches the RAM; the frame buffer may be written whenever pix_rd=0.

Optional Feature:
- Macro: WS2812_SCHED_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in FETCH/WAIT/SEND sets abort_req.
  - The current pixel finishes its 24 bits, then the block enters LATCH regardless of led_index.
  - frame_done pulses as normal and aborted=1 in the same cycle.
  - Exit goes to IDLE, ignoring continuous and start_pending (start_pending is cleared).
  - abort in IDLE or LATCH is ignored.
- Undefined: no ports added, behaviour exactly as above.

Test Plan:
- Bench config for all scenarios: NUM_LEDS=3, BIT_CYCLES=4, RESET_BITS=5.
- Single frame: start pulsed at cycle 0 → pix_rd at cycles 1/99/197 with addr 0/1/2; enc_load at 2/100/198; 72 bit_ticks in SEND; frame_done only at cycle 315; busy 0 from cycle 316.
- Pixel data: RAM={0xFF0000,0x00FF00,0x0000AA} → enc_pixel shows each value from the cycle after its enc_load; bit_index wraps 23→0 between pixels.
- Continuous: continuous=1, one start → frame_done at 315, 630 and 945; pix_rd addr 0 at 316; busy never drops.
- Pending start: start at cycles 0 and 50 → two frames back-to-back (second FETCH at cycle 316), then IDLE; a third start at cycle 60 is dropped.
- Reset mid-SEND: rst_n=0 at cycle 120 → same cycle all outputs 0 and busy=0; after release, start runs a clean frame from addr 0.
- With WS2812_SCHED_ABORT_EN: abort at cycle 110 (pixel 1) → pixel 1 completes at cycle 196; no pix_rd for addr 2; frame_done and aborted at 217; then IDLE.
